// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// One operation in flight: IDLE accepts, EXEC drives the adder and captures the sum, RESP holds it.
module adder_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_result,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_data,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = IDW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high
    // for the same requester bit; req_ready is one-hot and only ever high in IDLE, resp_valid
    // is one-hot and only high in RESP, and only resp_ready[grant_id] completes a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   grant_next;
    logic             grant_found;
    logic [CW-1:0]    scan_idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign add_a = op_a;
    assign add_b = op_b;

    // Scan from rr_ptr upward; the wrap is an explicit compare so non-power-of-2 counts work.
    always_comb begin
        grant_found = 1'b0;
        grant_next  = rr_ptr;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + CW'(k);
            if (scan_idx >= CW'(NUM_REQ)) begin
                scan_idx = scan_idx - CW'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_next  = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_next] = 1'b1;
                    state_next            = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            resp_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_found) begin
                op_a     <= req_a[int'(grant_next)*WIDTH +: WIDTH];
                op_b     <= req_b[int'(grant_next)*WIDTH +: WIDTH];
                grant_id <= grant_next;
            end
            if (state == EXEC) begin
                resp_data <= add_result;
            end
            // The requester just served drops to lowest priority.
            if (state == RESP && resp_ready[grant_id]) begin
                rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; the shared adder is modelled as a plain modulo sum.
module tb_adder_share_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_result;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic [NUM_REQ-1:0]       resp_ready;
    logic                     busy;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q[$];

    adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    assign add_result = add_a + add_b;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
        req_valid[i]         = v;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        tick();
        checks++;
        if ({req_ready, resp_valid, busy, add_a, add_b, resp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b resp_valid=%b busy=%b add_a=%0d add_b=%0d resp_data=%0d, want all 0",
                     req_ready, resp_valid, busy, add_a, add_b, resp_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single;
        drive_req(0, 1'b1, 8'd5, 8'd7);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_req_ready: got %b want 0001", req_ready);
        end
        tick();
        drive_req(0, 1'b0, 8'd0, 8'd0);
        checks++;
        if ({busy, add_a, add_b, resp_valid} !== {1'b1, 8'd5, 8'd7, 4'b0000}) begin
            errors++;
            $display("FAIL single_exec: busy=%b add_a=%0d add_b=%0d resp_valid=%b, want 1 5 7 0000",
                     busy, add_a, add_b, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_data !== 8'd12) begin
            errors++;
            $display("FAIL single_resp: resp_valid=%b resp_data=%0d, want 0001 12", resp_valid, resp_data);
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: busy=%b resp_valid=%b, want 0 0000", busy, resp_valid);
        end
    endtask

    task automatic test_overflow;
        drive_req(1, 1'b1, 8'd200, 8'd100);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL overflow_req_ready: got %b want 0010", req_ready);
        end
        tick();
        drive_req(1, 1'b0, 8'd0, 8'd0);
        tick();
        checks++;
        if (resp_valid !== 4'b0010 || resp_data !== 8'd44) begin
            errors++;
            $display("FAIL overflow_resp: resp_valid=%b resp_data=%0d, want 0010 44", resp_valid, resp_data);
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_round_robin;
        logic [WIDTH-1:0] op_a_tab [NUM_REQ];
        logic [WIDTH-1:0] op_b_tab [NUM_REQ];
        logic [WIDTH-1:0] sum_tab  [NUM_REQ];
        int grant_seq [5];
        op_a_tab = '{8'd13, 8'd73, 8'd133, 8'd193};
        op_b_tab = '{8'd200, 8'd14, 8'd84, 8'd154};
        sum_tab  = '{8'd213, 8'd87, 8'd217, 8'd91};
        grant_seq = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b1, op_a_tab[i], op_b_tab[i]);
        resp_ready = 4'b1111;
        foreach (grant_seq[n]) exp_q.push_back(sum_tab[grant_seq[n]]);
        for (int n = 0; n < 5; n++) begin
            logic [WIDTH-1:0] exp_sum;
            exp_sum = exp_q.pop_front();
            #1;
            checks++;
            if (req_ready !== 4'(1 << grant_seq[n])) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b want %b", n, req_ready, 4'(1 << grant_seq[n]));
            end
            tick();
            tick();
            checks++;
            if (resp_valid !== 4'(1 << grant_seq[n]) || resp_data !== exp_sum) begin
                errors++;
                $display("FAIL rr_resp%0d: resp_valid=%b resp_data=%0d, want %b %0d",
                         n, resp_valid, resp_data, 4'(1 << grant_seq[n]), exp_sum);
            end
            tick();
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    task automatic test_backpressure;
        apply_reset();
        drive_req(1, 1'b1, 8'd9, 8'd30);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant1: req_ready=%b want 0010", req_ready);
        end
        tick();
        drive_req(1, 1'b0, 8'd0, 8'd0);
        drive_req(2, 1'b1, 8'd50, 8'd60);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_exec_ready: req_ready=%b want 0000", req_ready);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 4'b0010 || resp_data !== 8'd39 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: resp_valid=%b resp_data=%0d req_ready=%b, want 0010 39 0000",
                         c, resp_valid, resp_data, req_ready);
            end
            tick();
        end
        resp_ready = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_handshake_ready: req_ready=%b want 0000", req_ready);
        end
        tick();
        resp_ready = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant2: req_ready=%b want 0100", req_ready);
        end
        tick();
        drive_req(2, 1'b0, 8'd0, 8'd0);
        tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_data !== 8'd110) begin
            errors++;
            $display("FAIL bp_resp2: resp_valid=%b resp_data=%0d, want 0100 110", resp_valid, resp_data);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_wrong_responder;
        drive_req(3, 1'b1, 8'd255, 8'd1);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wr_grant3: req_ready=%b want 1000", req_ready);
        end
        tick();
        drive_req(3, 1'b0, 8'd0, 8'd0);
        tick();
        resp_ready = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (resp_valid !== 4'b1000 || busy !== 1'b1 || resp_data !== 8'd0) begin
                errors++;
                $display("FAIL wr_hold%0d: resp_valid=%b busy=%b resp_data=%0d, want 1000 1 0",
                         c, resp_valid, busy, resp_data);
            end
            tick();
        end
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_release: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_op;
        // rr_ptr is 0 here after the previous response; serve 2 first to move it.
        drive_req(2, 1'b1, 8'd3, 8'd4);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_grant2: req_ready=%b want 0100", req_ready);
        end
        tick();
        drive_req(2, 1'b0, 8'd0, 8'd0);
        #1;
        checks++;
        if (busy !== 1'b1 || add_a !== 8'd3 || add_b !== 8'd4) begin
            errors++;
            $display("FAIL mid_exec: busy=%b add_a=%0d add_b=%0d, want 1 3 4", busy, add_a, add_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, add_a, add_b, resp_data} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: req_ready=%b resp_valid=%b busy=%b add_a=%0d add_b=%0d resp_data=%0d, want all 0",
                     req_ready, resp_valid, busy, add_a, add_b, resp_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_resp%0d: resp_valid=%b busy=%b, want 0000 0", c, resp_valid, busy);
            end
        end
        drive_req(0, 1'b1, 8'd1, 8'd2);
        drive_req(3, 1'b1, 8'd4, 8'd5);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_regrant: req_ready=%b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_data !== 8'd3) begin
            errors++;
            $display("FAIL mid_resp0: resp_valid=%b resp_data=%0d, want 0001 3", resp_valid, resp_data);
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_wrong_responder();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
